// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - access size encoding (SZ_B/SZ_H/SZ_W/SZ_D)
//   - responder FSM state type
//   - helpers for byte-enable, load masking and alignment checks
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Bytes touched by an access of the given size starting at the given lane.
    function automatic logic [7:0] byteMask(input logic [1:0] size, input logic [2:0] lane);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << lane;
    endfunction

    // Keeps the low (8 << size) bits of a right-aligned load result.
    function automatic logic [63:0] sizeMask(input logic [1:0] size);
        logic [63:0] m;
        case (size)
            SZ_B:    m = 64'h0000_0000_0000_00FF;
            SZ_H:    m = 64'h0000_0000_0000_FFFF;
            SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lane);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lane[0];
            SZ_W:    bad = |lane[1:0];
            default: bad = |lane;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 64-bit backing store.
//   clk     - clock
//   idx     - word index, shared by the read and write port
//   wrEn    - write strobe, qualified per byte by wrBe
//   wrBe    - byte enables (bit i covers wrData[8i+7:8i])
//   wrData  - lane-aligned write data
//   rdData  - combinational read of word idx
// Contents are deliberately not reset.
module dmem_array #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic                     wrEn,
    input  logic [7:0]               wrBe,
    input  logic [63:0]              wrData,
    output logic [63:0]              rdData
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int i = 0; i < 8; i++) begin
                if (wrBe[i]) begin
                    mem[idx][i*8 +: 8] <= wrData[i*8 +: 8];
                end
            end
        end
    end

    assign rdData = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side target for the core's load/store port.
// One request in flight; the response appears LATENCY cycles after accept.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | req_ready high, waiting for req_valid
//   WAIT  | request latched, counting down the remaining latency
//   RESP  | resp_valid high, rdata/err held until resp_ready
//
// Ports:
//   clk, rst                    - clock, synchronous active-low reset
//   req_valid/req_ready         - request handshake
//   req_addr/wen/size/wdata     - byte address, store flag, size code, right-aligned store data
//   resp_valid/resp_ready       - response handshake
//   resp_rdata                  - load data shifted to bit 0 (0 for stores and errors)
//   resp_err                    - misaligned or out-of-range access
//
// BASE must be 8-byte aligned: the word index is taken from the address
// bits directly, which is only equal to (addr - BASE) >> 3 in that case.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DATA_W  = 64,
    parameter int          ADDR_W  = 64,
    parameter int          DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int                IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] LIMIT_A  = ADDR_W'(BASE + 64'(DEPTH) * 64'd8);
    localparam logic [IDX_W-1:0]  BASE_IDX = BASE[IDX_W+2:3];
    localparam logic [3:0]        CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_e state, stateNext;
    logic [3:0] count;

    logic [ADDR_W-1:0] addrQ;
    logic              wenQ;
    logic [1:0]        sizeQ;
    logic [DATA_W-1:0] wdataQ;

    // With LATENCY==1 the RESP transition coincides with the accept edge,
    // so the access is evaluated from the live request while in IDLE.
    logic [ADDR_W-1:0] curAddr;
    logic              curWen;
    logic [1:0]        curSize;
    logic [DATA_W-1:0] curWdata;
    logic [2:0]        lane;
    logic [5:0]        shamt;
    logic              accErr;
    logic              accept;
    logic              enterResp;
    logic [IDX_W-1:0]  wordIdx;
    logic [63:0]       rdWord;
    logic [63:0]       loadData;
    logic              wrEn;

    always_comb begin
        if (state == IDLE) begin
            curAddr  = req_addr;
            curWen   = req_wen;
            curSize  = req_size;
            curWdata = req_wdata;
        end else begin
            curAddr  = addrQ;
            curWen   = wenQ;
            curSize  = sizeQ;
            curWdata = wdataQ;
        end
    end

    assign lane     = curAddr[2:0];
    assign shamt    = {lane, 3'b000};
    assign accErr   = misaligned(curSize, lane) || (curAddr < BASE_A) || (curAddr >= LIMIT_A);
    assign wordIdx  = curAddr[IDX_W+2:3] - BASE_IDX;
    assign loadData = (rdWord >> shamt) & sizeMask(curSize);

    assign accept    = (state == IDLE) && req_valid;
    assign enterResp = (accept && (LATENCY == 1)) || ((state == WAIT) && (count == 4'd0));
    // Gated by rst so a reset edge can never commit a store.
    assign wrEn      = rst && enterResp && curWen && !accErr;

    dmem_array #(
        .DEPTH (DEPTH)
    ) uArray (
        .clk    (clk),
        .idx    (wordIdx),
        .wrEn   (wrEn),
        .wrBe   (byteMask(curSize, lane)),
        .wrData (curWdata << shamt),
        .rdData (rdWord)
    );

    always_comb begin
        stateNext  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    stateNext = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (count == 4'd0) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= 4'd0;
            addrQ      <= '0;
            wenQ       <= 1'b0;
            sizeQ      <= 2'd0;
            wdataQ     <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= stateNext;

            if (accept) begin
                addrQ  <= req_addr;
                wenQ   <= req_wen;
                sizeQ  <= req_size;
                wdataQ <= req_wdata;
                count  <= CNT_INIT;
            end else if ((state == WAIT) && (count != 4'd0)) begin
                count <= count - 4'd1;
            end

            if (enterResp) begin
                resp_err   <= accErr;
                resp_rdata <= (accErr || curWen) ? '0 : loadData;
            end else if ((state == RESP) && resp_ready) begin
                resp_err   <= 1'b0;
                resp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] reqAddr;
    logic        reqWen;
    logic [1:0]  reqSize;
    logic [63:0] reqWdata;
    logic [2:0]  reqValid;
    logic [2:0]  respReady;
    logic [2:0]  reqReady;
    logic [2:0]  respValid;
    logic [2:0]  respErr;
    logic [63:0] rdata0, rdata1, rdata2;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(2)) u0 (
        .clk(clk), .rst(rst),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]),
        .req_addr(reqAddr), .req_wen(reqWen), .req_size(reqSize), .req_wdata(reqWdata),
        .resp_valid(respValid[0]), .resp_ready(respReady[0]),
        .resp_rdata(rdata0), .resp_err(respErr[0])
    );

    dmem_responder #(.LATENCY(1)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]),
        .req_addr(reqAddr), .req_wen(reqWen), .req_size(reqSize), .req_wdata(reqWdata),
        .resp_valid(respValid[1]), .resp_ready(respReady[1]),
        .resp_rdata(rdata1), .resp_err(respErr[1])
    );

    dmem_responder #(.LATENCY(5)) u2 (
        .clk(clk), .rst(rst),
        .req_valid(reqValid[2]), .req_ready(reqReady[2]),
        .req_addr(reqAddr), .req_wen(reqWen), .req_size(reqSize), .req_wdata(reqWdata),
        .resp_valid(respValid[2]), .resp_ready(respReady[2]),
        .resp_rdata(rdata2), .resp_err(respErr[2])
    );

    function automatic logic [63:0] rdataOf(input int u);
        case (u)
            0:       return rdata0;
            1:       return rdata1;
            default: return rdata2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request to instance u with resp_ready high and check the
    // response, its latency (negedges after the accept edge) and the return to IDLE.
    task automatic transact(input int u, input logic wen, input logic [1:0] size,
                            input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [63:0] expData, input logic expErr,
                            input int expLat, input string tag);
        int lat;
        @(negedge clk);
        reqWen = wen; reqSize = size; reqAddr = addr; reqWdata = wdata;
        reqValid[u] = 1'b1;
        check({tag, ".req_ready"}, 64'(reqReady[u]), 64'd1);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            reqValid[u] = 1'b0;
        end while (!respValid[u] && lat < 30);
        check({tag, ".latency"}, 64'(lat), 64'(expLat));
        check({tag, ".rdata"}, rdataOf(u), expData);
        check({tag, ".err"}, 64'(respErr[u]), 64'(expErr));
        @(negedge clk);
        check({tag, ".valid_drop"}, 64'(respValid[u]), 64'd0);
        check({tag, ".ready_back"}, 64'(reqReady[u]), 64'd1);
    endtask

    // Hold req_valid high and measure the spacing between accepts.
    task automatic backToBack(input int u, input int expPeriod, input string tag);
        int first, second, n;
        first = -1; second = -1; n = 0;
        @(negedge clk);
        reqWen = 1'b0; reqSize = 2'd3; reqAddr = 64'h8000_0010;
        respReady[u] = 1'b1;
        reqValid[u]  = 1'b1;
        while (second < 0 && n < 40) begin
            if (reqReady[u]) begin
                if (first < 0) first = n;
                else second = n;
            end
            @(negedge clk);
            n++;
        end
        reqValid[u] = 1'b0;
        check({tag, ".period"}, 64'(second - first), 64'(expPeriod));
        n = 0;
        while (!reqReady[u] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".drained"}, 64'(reqReady[u]), 64'd1);
    endtask

    initial begin
        rst = 1'b0;
        reqValid = 3'b000; respReady = 3'b111;
        reqAddr = '0; reqWen = 1'b0; reqSize = 2'd0; reqWdata = '0;
        repeat (2) @(negedge clk);
        check("rst.req_ready", 64'(reqReady), 64'b111);
        check("rst.resp_valid", 64'(respValid), 64'b000);
        check("rst.resp_err", 64'(respErr), 64'b000);
        check("rst.rdata", rdata0, 64'd0);
        rst = 1'b1;

        // LATENCY = 2
        transact(0, 1'b1, 2'd3, 64'h8000_0010, 64'h1122334455667788, 64'd0, 1'b0, 2, "stD");
        transact(0, 1'b0, 2'd3, 64'h8000_0010, 64'd0, 64'h1122334455667788, 1'b0, 2, "ldD");
        transact(0, 1'b1, 2'd0, 64'h8000_0013, 64'h00000000000000AA, 64'd0, 1'b0, 2, "stB");
        transact(0, 1'b0, 2'd3, 64'h8000_0010, 64'd0, 64'h11223344AA667788, 1'b0, 2, "ldMerge");
        transact(0, 1'b0, 2'd1, 64'h8000_0012, 64'd0, 64'h000000000000AA66, 1'b0, 2, "ldH");
        transact(0, 1'b0, 2'd2, 64'h8000_0006, 64'd0, 64'd0, 1'b1, 2, "misW");
        transact(0, 1'b1, 2'd3, 64'h8000_1FF8, 64'h5555AAAA5555AAAA, 64'd0, 1'b0, 2, "stLast");
        transact(0, 1'b1, 2'd3, 64'h7FFF_FFF8, 64'hDEADBEEFDEADBEEF, 64'd0, 1'b1, 2, "stBelow");
        transact(0, 1'b0, 2'd3, 64'h8000_1FF8, 64'd0, 64'h5555AAAA5555AAAA, 1'b0, 2, "ldLast");
        transact(0, 1'b0, 2'd3, 64'h8000_0010, 64'd0, 64'h11223344AA667788, 1'b0, 2, "ldKeep");
        transact(0, 1'b0, 2'd3, 64'h8000_2000, 64'd0, 64'd0, 1'b1, 2, "ldAbove");

        // Backpressure
        @(negedge clk);
        respReady[0] = 1'b0;
        reqWen = 1'b0; reqSize = 2'd3; reqAddr = 64'h8000_0010; reqValid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqValid[0] = 1'b0;
        @(negedge clk);
        check("bp.valid_up", 64'(respValid[0]), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp.valid", 64'(respValid[0]), 64'd1);
            check("bp.rdata", rdata0, 64'h11223344AA667788);
            check("bp.err", 64'(respErr[0]), 64'd0);
            check("bp.req_ready", 64'(reqReady[0]), 64'd0);
        end
        respReady[0] = 1'b1;
        @(negedge clk);
        check("bp.release_valid", 64'(respValid[0]), 64'd0);
        check("bp.release_ready", 64'(reqReady[0]), 64'd1);

        // Reset while a store waits
        transact(0, 1'b1, 2'd3, 64'h8000_0000, 64'd0, 64'd0, 1'b0, 2, "stZero");
        @(negedge clk);
        reqWen = 1'b1; reqSize = 2'd3; reqAddr = 64'h8000_0000;
        reqWdata = 64'hFFFF_FFFF_FFFF_FFFF; reqValid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqValid[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("midrst.valid", 64'(respValid[0]), 64'd0);
        check("midrst.req_ready", 64'(reqReady[0]), 64'd1);
        check("midrst.rdata", rdata0, 64'd0);
        check("midrst.err", 64'(respErr[0]), 64'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst.no_resp", 64'(respValid[0]), 64'd0);
        transact(0, 1'b0, 2'd3, 64'h8000_0000, 64'd0, 64'd0, 1'b0, 2, "midrst.ld");

        // LATENCY = 1
        transact(1, 1'b1, 2'd2, 64'h8000_0020, 64'h00000000CAFEBABE, 64'd0, 1'b0, 1, "l1.stW");
        transact(1, 1'b0, 2'd2, 64'h8000_0020, 64'd0, 64'h00000000CAFEBABE, 1'b0, 1, "l1.ldW");
        transact(1, 1'b0, 2'd0, 64'h8000_0021, 64'd0, 64'h00000000000000BA, 1'b0, 1, "l1.ldB");
        transact(1, 1'b0, 2'd1, 64'h8000_0022, 64'd0, 64'h000000000000CAFE, 1'b0, 1, "l1.ldH");
        transact(1, 1'b0, 2'd1, 64'h8000_0023, 64'd0, 64'd0, 1'b1, 1, "l1.misH");
        transact(1, 1'b1, 2'd3, 64'h8000_0010, 64'h0102030405060708, 64'd0, 1'b0, 1, "l1.stD");
        backToBack(1, 2, "l1.b2b");

        // LATENCY = 5
        transact(2, 1'b1, 2'd3, 64'h8000_0030, 64'h0123456789ABCDEF, 64'd0, 1'b0, 5, "l5.stD");
        transact(2, 1'b1, 2'd1, 64'h8000_0036, 64'h000000000000BEEF, 64'd0, 1'b0, 5, "l5.stH");
        transact(2, 1'b0, 2'd3, 64'h8000_0030, 64'd0, 64'hBEEF456789ABCDEF, 1'b0, 5, "l5.ldD");
        transact(2, 1'b0, 2'd0, 64'h8000_0037, 64'd0, 64'h00000000000000BE, 1'b0, 5, "l5.ldB");
        transact(2, 1'b0, 2'd3, 64'h8000_2000, 64'd0, 64'd0, 1'b1, 5, "l5.above");
        backToBack(2, 6, "l5.b2b");

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
